lfo_tremolo: RTL and testbench

Amplitude modulator that consumes the signed 32-bit triangle LFO value (`o_tri` of the triangle generator) and applies it as a time-varying gain to a 16-bit audio sample stream (tremolo effect). It sits between the audio sample source (codec/I2S receiver path) and the sample sink. It uses a valid/ready sample handshake with fixed latency and one sample in flight at a time.

---
 rtl/lfo_tremolo.sv | 106 ++++++++++
 tb/tb_lfo_tremolo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lfo_tremolo.sv
// Tremolo amplitude modulator: scales a 16-bit audio sample by an
// LFO-derived Q1.30 gain with a fixed four-cycle sample handshake.
module lfo_tremolo (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic signed [31:0] i_lfo,
    input  logic [2:0]         i_depth,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [15:0] i_sample,
    output logic               o_valid,
    output logic signed [15:0] o_sample
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAIN,
        S_MUL,
        S_OUT
    } state_t;

    localparam logic signed [31:0] POS_FS = 32'sh4000_0000;
    localparam logic signed [31:0] NEG_FS = 32'shC000_0000;
    localparam logic [30:0]        UNITY  = 31'h4000_0000;

    state_t             state;
    logic signed [15:0] smp;
    logic signed [31:0] lfo;
    logic [2:0]         dep;
    logic               en;
    logic [30:0]        g;

    logic signed [31:0] lfo_c;
    logic [32:0]        diff;
    logic [30:0]        m;
    logic [33:0]        scaled;
    logic [30:0]        a;
    logic [30:0]        g_next;
    logic signed [47:0] prod;
    logic               unused_bits;

    assign o_ready = (state == S_IDLE);

    always_comb begin
        lfo_c = lfo;
        if (lfo > POS_FS) begin
            lfo_c = POS_FS;
        end else if (lfo < NEG_FS) begin
            lfo_c = NEG_FS;
        end
    end

    // Clamped LFO maps to a modulation amount m in [0, 2^30].
    assign diff   = 33'h0_4000_0000 - {lfo_c[31], lfo_c};
    assign m      = diff[31:1];
    assign scaled = 34'(m) * 34'(dep);
    assign a      = scaled[33:3];
    assign g_next = (!en || dep == 3'd0) ? UNITY : UNITY - a;

    assign prod = 48'(smp) * 48'($signed({1'b0, g}));

    assign unused_bits = ^{diff[32], diff[0], scaled[2:0],
                           prod[47:46], prod[29:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            o_valid  <= 1'b0;
            o_sample <= '0;
            smp      <= '0;
            lfo      <= '0;
            dep      <= '0;
            en       <= 1'b0;
            g        <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        smp   <= i_sample;
                        lfo   <= i_lfo;
                        dep   <= i_depth;
                        en    <= i_start;
                        state <= S_GAIN;
                    end
                end
                S_GAIN: begin
                    g     <= g_next;
                    state <= S_MUL;
                end
                S_MUL: begin
                    // g <= 1.0, so the floored product always fits 16 bits.
                    o_sample <= prod[45:30];
                    o_valid  <= 1'b1;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfo_tremolo.sv
// Scoreboard bench for lfo_tremolo: directed samples with
// hand-computed gains, handshake spacing and mid-flight reset.
module tb_lfo_tremolo;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] lfo = '0;
    logic [2:0]         depth = '0;
    logic               vin = 1'b0;
    logic               rdy;
    logic signed [15:0] smp = '0;
    logic               vout;
    logic signed [15:0] sout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;

    logic signed [15:0] exp_v = '0;
    logic signed [15:0] q[$];
    int                 tq[$];

    lfo_tremolo dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_lfo    (lfo),
        .i_depth  (depth),
        .i_valid  (vin),
        .o_ready  (rdy),
        .i_sample (smp),
        .o_valid  (vout),
        .o_sample (sout)
    );

    always #5 clk = ~clk;

    // Accept tracker: pushes the expected result at the accept edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q.delete();
            tq.delete();
        end else if (vin && rdy) begin
            q.push_back(exp_v);
            tq.push_back(cyc);
            accepts <= accepts + 1;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        logic signed [15:0] e;
        int t;
        if (vout) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got %0d required none", sout);
            end else begin
                e = q.pop_front();
                t = tq.pop_front();
                if (sout !== e) begin
                    errors++;
                    $display("FAIL sample got %0d required %0d", sout, e);
                end
                checks++;
                if (cyc - t != 3) begin
                    errors++;
                    $display("FAIL latency got %0d required 3", cyc - t);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name,
                     $signed(got), $signed(req));
        end
    endtask

    task automatic send(input logic st, input logic signed [31:0] l,
                        input logic [2:0] d, input logic signed [15:0] s,
                        input logic signed [15:0] e);
        int n = 0;
        @(negedge clk);
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 required 1");
        end
        start = st;
        lfo   = l;
        depth = d;
        smp   = s;
        exp_v = e;
        vin   = 1'b1;
        @(negedge clk);
        vin   = 1'b0;
        start = ~st;
        lfo   = 32'sh7FFF_FFFF;
        depth = ~d;
        smp   = ~s;
        check("ready_low_after_accept", 32'(rdy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        int acc0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(rdy), 32'd1);
        check("reset_valid", 32'(vout), 32'd0);
        check("reset_sample", 32'(sout), 32'd0);
        rst = 1'b0;

        send(1'b1, 32'shC000_0000, 3'd0, 16'sd12345, 16'sd12345);
        send(1'b0, 32'shC000_0000, 3'd7, -16'sd20000, -16'sd20000);
        send(1'b1, 32'shC000_0000, 3'd4, 16'sd10000, 16'sd5000);
        send(1'b1, 32'sh8000_0000, 3'd4, 16'sd10000, 16'sd5000);
        send(1'b1, 32'shC000_0000, 3'd7, -16'sd32768, -16'sd4096);
        send(1'b1, 32'shC000_0000, 3'd7, 16'sd1001, 16'sd125);
        send(1'b1, 32'shC000_0000, 3'd7, -16'sd1001, -16'sd126);
        send(1'b1, 32'sh7FFF_FFFF, 3'd7, 16'sd777, 16'sd777);
        send(1'b1, 32'sh0000_0000, 3'd4, 16'sd1000, 16'sd750);
        send(1'b1, 32'sh0000_0000, 3'd7, 16'sd1600, 16'sd900);

        // Continuous valid: accepts every fourth cycle.
        @(negedge clk);
        acc0  = accepts;
        start = 1'b1;
        lfo   = '0;
        depth = 3'd0;
        vin   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp   = 16'(100 * i + 1);
            exp_v = smp;
            check("handshake_ready", 32'(rdy), 32'((i % 4) == 0));
            @(negedge clk);
        end
        vin = 1'b0;
        repeat (4) @(negedge clk);
        check("handshake_accepts", 32'(accepts - acc0), 32'd3);

        // Reset while the sample sits in S_MUL.
        @(negedge clk);
        start = 1'b1;
        lfo   = '0;
        depth = 3'd0;
        smp   = 16'sd1111;
        exp_v = 16'sd1111;
        vin   = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_sample", 32'(sout), 32'd0);
        check("midreset_ready", 32'(rdy), 32'd1);
        check("midreset_valid", 32'(vout), 32'd0);
        repeat (4) @(negedge clk);

        send(1'b1, 32'sh0000_0000, 3'd4, -16'sd1000, -16'sd750);
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
